// File: rtl/multicycle_control_unit_if.sv
// Bus bundle between the multicycle control unit (master) and the core datapath/memories (slave).
interface multicycle_control_unit_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                   instr_req;
    logic [INSTR_WIDTH-1:0] instr_in;
    logic                   instr_valid;
    logic [DATA_WIDTH-1:0]  pc_in;
    logic [DATA_WIDTH-1:0]  regin1;
    logic [DATA_WIDTH-1:0]  regin2;
    logic [DATA_WIDTH-1:0]  aluin;
    logic [DATA_WIDTH-1:0]  aluout1;
    logic [DATA_WIDTH-1:0]  aluout2;
    logic [DATA_WIDTH-1:0]  regout;
    logic                   write_enable;
    logic                   data_mem_req;
    logic                   data_mem_write_enable;
    logic [DATA_WIDTH-1:0]  data_mem_base_address;
    logic [DATA_WIDTH-1:0]  data_mem_offset;
    logic [DATA_WIDTH-1:0]  data_mem_write_data;
    logic [DATA_WIDTH-1:0]  data_mem_read_data;
    logic                   data_mem_ack;
    logic                   branch;
    logic [DATA_WIDTH-1:0]  offset;
    logic                   pc_update;
    logic                   illegal_op;
    logic                   busy;

    modport master (
        output instr_req, aluout1, aluout2, regout, write_enable,
               data_mem_req, data_mem_write_enable, data_mem_base_address,
               data_mem_offset, data_mem_write_data, branch, offset,
               pc_update, illegal_op, busy,
        input  instr_in, instr_valid, pc_in, regin1, regin2, aluin,
               data_mem_read_data, data_mem_ack
    );

    modport slave (
        input  instr_req, aluout1, aluout2, regout, write_enable,
               data_mem_req, data_mem_write_enable, data_mem_base_address,
               data_mem_offset, data_mem_write_data, branch, offset,
               pc_update, illegal_op, busy,
        output instr_in, instr_valid, pc_in, regin1, regin2, aluin,
               data_mem_read_data, data_mem_ack
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit; every output is registered on the edge entering its state.
// Define ILLEGAL_OP_TRAP_EN to trap opcodes above 24 in a sticky TRAP state (default: they run as NOPs).
module multicycle_control_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    multicycle_control_unit_if.master bus
);
    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;
`ifdef ILLEGAL_OP_TRAP_EN
    localparam logic [2:0] TRAP   = 3'd5;
`endif
    localparam logic [5:0] OP_LOAD  = 6'd12;
    localparam logic [5:0] OP_STORE = 6'd13;
    localparam logic [5:0] OP_JMP   = 6'd20;
    localparam logic [5:0] OP_JR    = 6'd21;
    localparam logic [5:0] OP_JAL   = 6'd22;
    localparam logic [5:0] OP_LAST  = 6'd24;

    function automatic logic [DATA_WIDTH-1:0] sext16(input logic [15:0] v);
        return DATA_WIDTH'($signed(v));
    endfunction

    function automatic logic uses_imm(input logic [5:0] op);
        case (op)
            6'd4, 6'd5, 6'd8, 6'd9, 6'd10, 6'd11, 6'd24: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

    function automatic logic writes_reg(input logic [5:0] op);
        return (op <= OP_LOAD) || ((op >= OP_JAL) && (op <= OP_LAST));
    endfunction

    function automatic logic is_cond_branch(input logic [5:0] op);
        return (op >= 6'd14) && (op <= 6'd19);
    endfunction

    logic [2:0]             state_r, next_state_s;
    logic [INSTR_WIDTH-1:0] ir_r;
    logic [5:0]             opcode_s;
    logic [DATA_WIDTH-1:0]  alu_r, alu_s, split_s;
    logic [DATA_WIDTH-1:0]  wb_offset_s, wb_regout_s;
    logic                   wb_branch_s, fetch_s;

    logic                   instr_req_r, busy_r, write_enable_r, pc_update_r, branch_r;
    logic                   mem_req_r, mem_we_r;
    logic [DATA_WIDTH-1:0]  aluout1_r, aluout2_r, regout_r, offset_r;
    logic [DATA_WIDTH-1:0]  mem_base_r, mem_off_r, mem_wdata_r;

    assign opcode_s = ir_r[INSTR_WIDTH-1 -: 6];
    assign fetch_s  = instr_req_r & bus.instr_valid;

    // Next-state sequencing.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            FETCH:  next_state_s = fetch_s ? DECODE : FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
            DECODE: next_state_s = (opcode_s > OP_LAST) ? TRAP : EXEC;
            TRAP:   next_state_s = TRAP;
`else
            DECODE: next_state_s = EXEC;
`endif
            EXEC:   next_state_s = ((opcode_s == OP_LOAD) || (opcode_s == OP_STORE)) ? MEM : WB;
            MEM:    next_state_s = bus.data_mem_ack ? WB : MEM;
            WB:     next_state_s = FETCH;
            default: next_state_s = FETCH;
        endcase
    end

    // Write-back values; the ALU result comes straight from aluin when entering WB from EXEC.
    always_comb begin
        alu_s       = (state_r == EXEC) ? bus.aluin : alu_r;
        split_s     = sext16({ir_r[25:21], ir_r[10:0]});
        wb_branch_s = 1'b0;
        wb_offset_s = '0;
        case (opcode_s)
            OP_JMP, OP_JAL: begin
                wb_branch_s = 1'b1;
                wb_offset_s = DATA_WIDTH'(ir_r[25:0]);
            end
            OP_JR: begin
                wb_branch_s = 1'b1;
                wb_offset_s = bus.regin1;
            end
            default: begin
                if (is_cond_branch(opcode_s)) begin
                    wb_branch_s = |alu_s;
                    wb_offset_s = split_s;
                end else begin
                    wb_branch_s = 1'b0;
                    wb_offset_s = '0;
                end
            end
        endcase
        if (opcode_s == OP_LOAD) begin
            wb_regout_s = bus.data_mem_read_data;
        end else if (opcode_s == OP_JAL) begin
            wb_regout_s = bus.pc_in + DATA_WIDTH'(1'b1);
        end else begin
            wb_regout_s = alu_s;
        end
    end

    // State and instruction register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FETCH;
            ir_r    <= '0;
        end else begin
            state_r <= next_state_s;
            if ((state_r == FETCH) && fetch_s) begin
                ir_r <= bus.instr_in;
            end
        end
    end

    // Output registers, each group loaded on the transition into the state that owns it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_req_r    <= 1'b0;
            busy_r         <= 1'b0;
            write_enable_r <= 1'b0;
            pc_update_r    <= 1'b0;
            branch_r       <= 1'b0;
            mem_req_r      <= 1'b0;
            mem_we_r       <= 1'b0;
            alu_r          <= '0;
            aluout1_r      <= '0;
            aluout2_r      <= '0;
            regout_r       <= '0;
            offset_r       <= '0;
            mem_base_r     <= '0;
            mem_off_r      <= '0;
            mem_wdata_r    <= '0;
        end else begin
            instr_req_r <= (next_state_s == FETCH);
            busy_r      <= (next_state_s != FETCH);
            if (state_r == DECODE) begin
                aluout1_r <= bus.regin1;
                aluout2_r <= uses_imm(opcode_s) ? DATA_WIDTH'(ir_r[15:0]) : bus.regin2;
            end
            if (state_r == EXEC) begin
                alu_r <= bus.aluin;
            end
            if ((state_r == EXEC) && (next_state_s == MEM)) begin
                mem_req_r   <= 1'b1;
                mem_we_r    <= (opcode_s == OP_STORE);
                mem_base_r  <= bus.regin2;
                mem_off_r   <= (opcode_s == OP_LOAD) ? sext16(ir_r[15:0]) : split_s;
                mem_wdata_r <= bus.regin1;
            end else if ((state_r == MEM) && bus.data_mem_ack) begin
                mem_req_r <= 1'b0;
                mem_we_r  <= 1'b0;
            end
            if (next_state_s == WB) begin
                pc_update_r    <= 1'b1;
                write_enable_r <= writes_reg(opcode_s);
                regout_r       <= wb_regout_s;
                branch_r       <= wb_branch_s;
                offset_r       <= wb_offset_s;
            end else begin
                pc_update_r    <= 1'b0;
                write_enable_r <= 1'b0;
            end
        end
    end

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal_op_r;

    // Sticky trap flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_op_r <= 1'b0;
        end else if (next_state_s == TRAP) begin
            illegal_op_r <= 1'b1;
        end
    end
    assign bus.illegal_op = illegal_op_r;
`else
    assign bus.illegal_op = 1'b0;
`endif

    assign bus.instr_req             = instr_req_r;
    assign bus.busy                  = busy_r;
    assign bus.aluout1               = aluout1_r;
    assign bus.aluout2               = aluout2_r;
    assign bus.regout                = regout_r;
    assign bus.write_enable          = write_enable_r;
    assign bus.data_mem_req          = mem_req_r;
    assign bus.data_mem_write_enable = mem_we_r;
    assign bus.data_mem_base_address = mem_base_r;
    assign bus.data_mem_offset       = mem_off_r;
    assign bus.data_mem_write_data   = mem_wdata_r;
    assign bus.branch                = branch_r;
    assign bus.offset                = offset_r;
    assign bus.pc_update             = pc_update_r;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed vector table, random instructions vs. a spec-level model.
module tb_multicycle_control_unit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_control_unit_if #(.DATA_WIDTH(32), .INSTR_WIDTH(32)) bus ();
    multicycle_control_unit #(.DATA_WIDTH(32), .INSTR_WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [31:0] ir, r1, r2, alu, pc, rdata;
        int          waits;
        int          lat;
        logic        we;
        logic [31:0] regout;
        logic        br;
        logic [31:0] off;
        logic [31:0] a2;
        int          reqs;
        logic        mwe;
        logic [31:0] moff;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];

    task automatic check(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h, expected %h", tag, what, act, exp);
        end
    endtask

    function automatic logic any_out();
        return |{bus.instr_req, bus.aluout1, bus.aluout2, bus.regout, bus.write_enable,
                 bus.data_mem_req, bus.data_mem_write_enable, bus.data_mem_base_address,
                 bus.data_mem_offset, bus.data_mem_write_data, bus.branch, bus.offset,
                 bus.pc_update, bus.illegal_op, bus.busy};
    endfunction

    function automatic vec_t mk(input logic [31:0] ir, r1, r2, alu, pc, rdata, input int waits,
                                input int lat, input logic we, input logic [31:0] regout,
                                input logic br, input logic [31:0] off, input logic [31:0] a2,
                                input int reqs, input logic mwe, input logic [31:0] moff);
        vec_t v;
        v.ir = ir; v.r1 = r1; v.r2 = r2; v.alu = alu; v.pc = pc; v.rdata = rdata; v.waits = waits;
        v.lat = lat; v.we = we; v.regout = regout; v.br = br; v.off = off; v.a2 = a2;
        v.reqs = reqs; v.mwe = mwe; v.moff = moff;
        return v;
    endfunction

    function automatic logic [31:0] sx(input logic [15:0] x);
        return (x >= 16'h8000) ? (32'hFFFF_0000 | {16'h0, x}) : {16'h0, x};
    endfunction

    // Reference model: expected results straight from the opcode rules.
    function automatic vec_t predict(input vec_t v);
        vec_t        e;
        int          op;
        logic [15:0] split;
        e     = v;
        op    = int'(v.ir[31:26]);
        split = {v.ir[25:21], v.ir[10:0]};
        e.lat    = (op == 12 || op == 13) ? 5 + v.waits : 4;
        e.reqs   = (op == 12 || op == 13) ? v.waits + 1 : 0;
        e.mwe    = (op == 13);
        e.moff   = (op == 12) ? sx(v.ir[15:0]) : sx(split);
        e.a2     = (op inside {4, 5, 8, 9, 10, 11, 24}) ? {16'h0, v.ir[15:0]} : v.r2;
        e.we     = (op <= 12) || (op >= 22 && op <= 24);
        e.regout = (op == 12) ? v.rdata : (op == 22) ? v.pc + 32'd1 : v.alu;
        e.br     = (op >= 20 && op <= 22) || (op >= 14 && op <= 19 && v.alu != 32'h0);
        e.off    = (op == 20 || op == 22) ? {6'h0, v.ir[25:0]} :
                   (op == 21) ? v.r1 :
                   (op >= 14 && op <= 19) ? sx(split) : 32'h0;
        return e;
    endfunction

    task automatic wait_req(input string tag);
        int k;
        k = 0;
        while (bus.instr_req !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check(tag, "instr_req", bus.instr_req, 32'h1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int          cyc, reqs, wes, pus, bad_mwe, bad_busy;
        bit          done;
        logic [31:0] g_base, g_moff, g_wdata, g_regout, g_off, g_a1, g_a2;
        logic        g_br, g_we, g_ill;
        cyc = 1; reqs = 0; wes = 0; pus = 0; bad_mwe = 0; bad_busy = 0; done = 1'b0;
        g_base = 0; g_moff = 0; g_wdata = 0; g_regout = 0; g_off = 0; g_a1 = 0; g_a2 = 0;
        g_br = 0; g_we = 0; g_ill = 0;
        wait_req(tag);
        bus.regin1 = v.r1; bus.regin2 = v.r2; bus.aluin = v.alu; bus.pc_in = v.pc;
        bus.data_mem_read_data = v.rdata;
        bus.instr_in = v.ir; bus.instr_valid = 1'b1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            bus.instr_in = ~v.ir;
            if (bus.busy !== 1'b1) bad_busy++;
            if (bus.data_mem_req === 1'b1) begin
                reqs++;
                if (reqs == 1) begin
                    g_base = bus.data_mem_base_address; g_moff = bus.data_mem_offset;
                    g_wdata = bus.data_mem_write_data;
                end
                if (bus.data_mem_write_enable !== v.mwe) bad_mwe++;
                bus.data_mem_ack = (reqs == v.waits + 1);
            end else begin
                if (bus.data_mem_write_enable !== 1'b0) bad_mwe++;
                bus.data_mem_ack = 1'($urandom_range(0, 1));
            end
            if (bus.write_enable === 1'b1) wes++;
            if (bus.pc_update === 1'b1) begin
                pus++; done = 1'b1;
                g_regout = bus.regout; g_off = bus.offset; g_br = bus.branch; g_we = bus.write_enable;
                g_a1 = bus.aluout1; g_a2 = bus.aluout2; g_ill = bus.illegal_op;
            end
        end
        bus.instr_valid = 1'b0;
        bus.data_mem_ack = 1'b0;
        check(tag, "completed", {31'h0, done}, 32'h1);
        check(tag, "latency", 32'(cyc), 32'(v.lat));
        check(tag, "pc_update_count", 32'(pus), 32'h1);
        check(tag, "write_enable", {31'h0, g_we}, {31'h0, v.we});
        check(tag, "write_enable_count", 32'(wes), v.we ? 32'h1 : 32'h0);
        if (v.we) check(tag, "regout", g_regout, v.regout);
        check(tag, "branch", {31'h0, g_br}, {31'h0, v.br});
        check(tag, "offset", g_off, v.off);
        check(tag, "aluout1", g_a1, v.r1);
        check(tag, "aluout2", g_a2, v.a2);
        check(tag, "illegal_op", {31'h0, g_ill}, 32'h0);
        check(tag, "mem_req_cycles", 32'(reqs), 32'(v.reqs));
        if (v.reqs > 0) begin
            check(tag, "mem_base", g_base, v.r2);
            check(tag, "mem_offset", g_moff, v.moff);
            check(tag, "mem_wdata", g_wdata, v.r1);
        end
        check(tag, "mem_we_qualifier", 32'(bad_mwe), 32'h0);
        check(tag, "busy_in_flight", 32'(bad_busy), 32'h0);
        @(negedge clk);
        check(tag, "back_in_fetch", {28'h0, bus.pc_update, bus.write_enable, bus.busy, bus.instr_req}, 32'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   op, k, pu, rq;
        rst_n = 1'b0;
        bus.instr_in = '0; bus.instr_valid = 1'b0; bus.pc_in = '0; bus.regin1 = '0; bus.regin2 = '0;
        bus.aluin = '0; bus.data_mem_read_data = '0; bus.data_mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("reset", "all_outputs", {31'h0, any_out()}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset", "instr_req_after_release", {31'h0, bus.instr_req}, 32'h1);
        check("reset", "busy_after_release", {31'h0, bus.busy}, 32'h0);

        //             ir            r1          r2          alu          pc        rdata     w  lat we regout        br off            a2         rq mwe moff
        vecs.push_back(mk(32'h0022_3800, 32'd5,      32'd7,      32'd12,      32'h0,  32'h0,    0, 4, 1, 32'd12,      0, 32'h0,         32'd7,     0, 0, 32'h0));
        vecs.push_back(mk(32'h3000_FFFC, 32'h11,     32'h100,    32'hFC,      32'h0,  32'hDEAD, 3, 8, 1, 32'hDEAD,    0, 32'h0,         32'h100,   4, 0, 32'hFFFF_FFFC));
        vecs.push_back(mk(32'h3420_0004, 32'hCAFE,   32'h200,    32'h204,     32'h0,  32'h5555, 1, 6, 0, 32'h0,       0, 32'h0,         32'h200,   2, 1, 32'h804));
        vecs.push_back(mk(32'h3BE0_07F0, 32'd3,      32'd3,      32'd0,       32'h0,  32'h0,    0, 4, 0, 32'h0,       0, 32'hFFFF_FFF0, 32'd3,     0, 0, 32'h0));
        vecs.push_back(mk(32'h3BE0_07F0, 32'd3,      32'd3,      32'd1,       32'h0,  32'h0,    0, 4, 0, 32'h0,       1, 32'hFFFF_FFF0, 32'd3,     0, 0, 32'h0));
        vecs.push_back(mk(32'h5812_3456, 32'd1,      32'd9,      32'h77,      32'h40, 32'h0,    0, 4, 1, 32'h41,      1, 32'h0012_3456, 32'd9,     0, 0, 32'h0));
        vecs.push_back(mk(32'h1000_8001, 32'd1,      32'h55,     32'h8002,    32'h0,  32'h0,    0, 4, 1, 32'h8002,    0, 32'h0,         32'h8001,  0, 0, 32'h0));
        vecs.push_back(mk(32'h5400_0000, 32'h1234,   32'd2,      32'd0,       32'h0,  32'h0,    0, 4, 0, 32'h0,       1, 32'h1234,      32'd2,     0, 0, 32'h0));
        vecs.push_back(mk(32'h53FF_FFFF, 32'd0,      32'd4,      32'd0,       32'h0,  32'h0,    0, 4, 0, 32'h0,       1, 32'h03FF_FFFF, 32'd4,     0, 0, 32'h0));
        vecs.push_back(mk(32'h5C00_0000, 32'd1,      32'd2,      32'hABCD,    32'h0,  32'h0,    0, 4, 1, 32'hABCD,    0, 32'h0,         32'd2,     0, 0, 32'h0));
        vecs.push_back(mk(32'h4040_8010, 32'd0,      32'd6,      32'd7,       32'h0,  32'h0,    0, 4, 0, 32'h0,       1, 32'h1010,      32'd6,     0, 0, 32'h0));
        vecs.push_back(mk(32'h6000_F00F, 32'd1,      32'd3,      32'd5,       32'h0,  32'h0,    0, 4, 1, 32'd5,       0, 32'h0,         32'hF00F,  0, 0, 32'h0));
        vecs.push_back(mk(32'h3000_0010, 32'd0,      32'h300,    32'd0,       32'h0,  32'hBEEF, 0, 5, 1, 32'hBEEF,    0, 32'h0,         32'h300,   1, 0, 32'h10));
`ifndef ILLEGAL_OP_TRAP_EN
        vecs.push_back(mk(32'h7800_FFFF, 32'd1,      32'd2,      32'd3,       32'h0,  32'h0,    0, 4, 0, 32'h0,       0, 32'h0,         32'd2,     0, 0, 32'h0));
`endif
        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 60; i++) begin
`ifdef ILLEGAL_OP_TRAP_EN
            op = int'($urandom_range(0, 24));
`else
            op = int'($urandom_range(0, 63));
`endif
            v.ir    = {op[5:0], 26'($urandom)};
            v.r1    = $urandom;
            v.r2    = $urandom;
            v.alu   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            v.pc    = $urandom;
            v.rdata = $urandom;
            v.waits = int'($urandom_range(0, 4));
            run_vec(predict(v), $sformatf("rand%0d_op%0d", i, op));
        end

        // Reset while a load waits for its acknowledge.
        wait_req("rst_mem");
        bus.instr_in = 32'h3000_0010; bus.instr_valid = 1'b1; bus.data_mem_ack = 1'b0;
        k = 0;
        while (bus.data_mem_req !== 1'b1 && k < 10) begin
            @(negedge clk);
            bus.instr_valid = 1'b0;
            k++;
        end
        check("rst_mem", "mem_req_seen", {31'h0, bus.data_mem_req}, 32'h1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_mem", "all_outputs_same_cycle", {31'h0, any_out()}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mem", "instr_req_after_release", {31'h0, bus.instr_req}, 32'h1);
        run_vec(vecs[0], "post_reset_add");

`ifdef ILLEGAL_OP_TRAP_EN
        wait_req("trap");
        bus.instr_in = 32'h7800_0000; bus.instr_valid = 1'b1;
        pu = 0; rq = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.pc_update === 1'b1) pu++;
            if (bus.instr_req !== 1'b0) rq++;
        end
        bus.instr_valid = 1'b0;
        check("trap", "illegal_op_sticky", {31'h0, bus.illegal_op}, 32'h1);
        check("trap", "pc_update_count", 32'(pu), 32'h0);
        check("trap", "instr_req_cycles", 32'(rq), 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("trap", "cleared_by_reset", {31'h0, bus.illegal_op}, 32'h0);
`else
        pu = 0; rq = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
